// File: rtl/sample_frame_controller.sv
// Purpose : frame parser/sequencer ahead of the byte demux (sync hunt, length, payload forward, XOR check).
// Latency : every output is registered, one cycle after the rxValid byte (or the timeout cycle) that causes it.
// Backpressure: none; accepts one byte per cycle in every state, so rxValid may be asserted back-to-back.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   rxValid      one-cycle strobe, rxData holds a new byte
//   rxData       incoming byte
//   demuxEnable  one-cycle strobe forwarding demuxData to the demux
//   demuxData    payload byte, valid with demuxEnable
//   demuxReset   one-cycle pulse realigning the demux byte index
//   frameActive  high while in LENGTH/PAYLOAD/CHECK
//   frameDone    one-cycle pulse after the checksum byte is consumed
//   error        one-cycle pulse on bad checksum, zero length or timeout
module sample_frame_controller #(
  parameter int         blockSize     = 2,
  parameter logic [7:0] syncByte      = 8'hA5,
  parameter int         timeoutCycles = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxValid,
  input  logic [7:0] rxData,
  output logic       demuxEnable,
  output logic [7:0] demuxData,
  output logic       demuxReset,
  output logic       frameActive,
  output logic       frameDone,
  output logic       error
);

  // Largest frame is 255 samples, so the payload counter can never wrap.
  localparam int cnt_w  = $clog2(255 * blockSize + 1);
  localparam int idle_w = $clog2(timeoutCycles);
  localparam logic [idle_w-1:0] idle_last = idle_w'(timeoutCycles - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LENGTH  = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [cnt_w-1:0]  byte_cnt, byte_cnt_nxt;
  logic [7:0]        checksum, checksum_nxt;
  logic [idle_w-1:0] idle_cnt, idle_cnt_nxt;

  logic       demux_en_nxt;
  logic [7:0] demux_dat_nxt;
  logic       demux_rst_nxt;
  logic       done_nxt;
  logic       error_nxt;
  logic       timeout;

  // A byte arriving in the expiry cycle takes priority: timeout requires !rxValid.
  assign timeout     = (state != HUNT) && !rxValid && (idle_cnt == idle_last);
  assign frameActive = (state != HUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      byte_cnt    <= '0;
      checksum    <= '0;
      idle_cnt    <= '0;
      demuxEnable <= 1'b0;
      demuxData   <= '0;
      demuxReset  <= 1'b0;
      frameDone   <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      checksum    <= checksum_nxt;
      idle_cnt    <= idle_cnt_nxt;
      demuxEnable <= demux_en_nxt;
      demuxData   <= demux_dat_nxt;
      demuxReset  <= demux_rst_nxt;
      frameDone   <= done_nxt;
      error       <= error_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    checksum_nxt  = checksum;
    idle_cnt_nxt  = idle_cnt;
    demux_en_nxt  = 1'b0;
    demux_dat_nxt = demuxData;
    demux_rst_nxt = 1'b0;
    done_nxt      = 1'b0;
    error_nxt     = 1'b0;

    // Idle counter only runs inside a frame; any byte restarts it.
    if (state == HUNT || rxValid) begin
      idle_cnt_nxt = '0;
    end else begin
      idle_cnt_nxt = idle_cnt + 1'b1;
    end

    if (timeout) begin
      // Abort the partial frame and realign the demux for the next one.
      state_nxt     = HUNT;
      byte_cnt_nxt  = '0;
      checksum_nxt  = '0;
      idle_cnt_nxt  = '0;
      demux_rst_nxt = 1'b1;
      error_nxt     = 1'b1;
    end else if (rxValid) begin
      unique case (state)
        HUNT: begin
          if (rxData == syncByte) begin
            state_nxt     = LENGTH;
            demux_rst_nxt = 1'b1;
          end
        end
        LENGTH: begin
          // A sync value here is a legal length, never a resync.
          if (rxData == 8'h00) begin
            state_nxt = HUNT;
            error_nxt = 1'b1;
          end else begin
            state_nxt    = PAYLOAD;
            byte_cnt_nxt = cnt_w'(rxData) * cnt_w'(blockSize);
            checksum_nxt = '0;
          end
        end
        PAYLOAD: begin
          demux_en_nxt  = 1'b1;
          demux_dat_nxt = rxData;
          checksum_nxt  = checksum ^ rxData;
          byte_cnt_nxt  = byte_cnt - 1'b1;
          if (byte_cnt == cnt_w'(1)) begin
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          // Samples already forwarded stand even if the checksum fails.
          state_nxt    = HUNT;
          done_nxt     = 1'b1;
          error_nxt    = (rxData != checksum);
          byte_cnt_nxt = '0;
          checksum_nxt = '0;
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_frame_controller.sv
module tb_sample_frame_controller;

  localparam int TO = 32;

  logic       clk;
  logic       reset;
  logic       rxValid;
  logic [7:0] rxData;
  logic       demuxEnable;
  logic [7:0] demuxData;
  logic       demuxReset;
  logic       frameActive;
  logic       frameDone;
  logic       error;

  int checks;
  int failures;

  sample_frame_controller #(
    .blockSize    (2),
    .syncByte     (8'hA5),
    .timeoutCycles(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxValid    (rxValid),
    .rxData     (rxData),
    .demuxEnable(demuxEnable),
    .demuxData  (demuxData),
    .demuxReset (demuxReset),
    .frameActive(frameActive),
    .frameDone  (frameDone),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One input cycle and the outputs expected just after the edge that consumes it.
  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       en;
    logic [7:0] edat;
    logic       rst;
    logic       act;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic vld, input logic [7:0] dat, input logic en,
                             input logic [7:0] edat, input logic rst, input logic act,
                             input logic done, input logic err);
    vec_t r;
    r.vld = vld; r.dat = dat; r.en = en; r.edat = edat;
    r.rst = rst; r.act = act; r.done = done; r.err = err;
    return r;
  endfunction

  // demuxData is only meaningful while demuxEnable is expected high.
  task automatic check(input logic en, input logic [7:0] edat, input logic rst,
                       input logic act, input logic done, input logic err, input string name);
    logic [12:0] got, exp;
    got = {demuxEnable, (en ? demuxData : 8'h00), demuxReset, frameActive, frameDone, error};
    exp = {en, (en ? edat : 8'h00), rst, act, done, err};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got en=%b dat=%h rst=%b act=%b done=%b err=%b required en=%b dat=%h rst=%b act=%b done=%b err=%b",
               name, demuxEnable, demuxData, demuxReset, frameActive, frameDone, error,
               en, edat, rst, act, done, err);
    end
  endtask

  task automatic step(input logic vld, input logic [7:0] dat, input logic en,
                      input logic [7:0] edat, input logic rst, input logic act,
                      input logic done, input logic err, input string name);
    rxValid = vld;
    rxData  = dat;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
    check(en, edat, rst, act, done, err, name);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    rxValid  = 1'b0;
    rxData   = 8'h00;

    // Good frame, checksum 11^22^33^44 = 44; the next frame abuts it.
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(v(1, 8'h02, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h11, 1, 8'h11, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h22, 1, 8'h22, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h33, 1, 8'h33, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h44, 1, 8'h44, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h44, 0, 8'h00, 0, 0, 1, 0));
    // Same payload, wrong checksum: done and error together.
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(v(1, 8'h02, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h11, 1, 8'h11, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h22, 1, 8'h22, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h33, 1, 8'h33, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h44, 1, 8'h44, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h00, 0, 8'h00, 0, 0, 1, 1));
    // Zero length, then a one-sample frame, checksum AA^BB = 11.
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(v(1, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'hAA, 1, 8'hAA, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'hBB, 1, 8'hBB, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h11, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    // Junk before sync is dropped; an idle gap inside the payload is tolerated.
    tbl.push_back(v(1, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'hFF, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h5A, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h01, 1, 8'h01, 0, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h02, 1, 8'h02, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h03, 0, 8'h00, 0, 0, 1, 0));
    // Sync value inside the payload is plain data.
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'hA5, 1, 8'hA5, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'h00, 1, 8'h00, 0, 1, 0, 0));
    tbl.push_back(v(1, 8'hA5, 0, 8'h00, 0, 0, 1, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check(0, 8'h00, 0, 0, 0, 0, "reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check(0, 8'h00, 0, 0, 0, 0, "post_release");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].vld, tbl[i].dat, tbl[i].en, tbl[i].edat, tbl[i].rst, tbl[i].act,
           tbl[i].done, tbl[i].err, $sformatf("vec%0d", i));
    end

    // Timeout: TO idle cycles inside a frame abort it.
    step(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, "t5_sync");
    step(1, 8'h02, 0, 8'h00, 0, 1, 0, 0, "t5_len");
    step(1, 8'h11, 1, 8'h11, 0, 1, 0, 0, "t5_b0");
    for (int i = 0; i < TO - 1; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, "t5_idle");
    end
    step(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "t5_abort");
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "t5_after");
    step(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, "t5g_sync");
    step(1, 8'h01, 0, 8'h00, 0, 1, 0, 0, "t5g_len");
    step(1, 8'hAA, 1, 8'hAA, 0, 1, 0, 0, "t5g_b0");
    step(1, 8'hBB, 1, 8'hBB, 0, 1, 0, 0, "t5g_b1");
    step(1, 8'h11, 0, 8'h00, 0, 0, 1, 0, "t5g_chk");

    // A byte in the expiry cycle wins over the timeout.
    step(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, "exp_sync");
    step(1, 8'h01, 0, 8'h00, 0, 1, 0, 0, "exp_len");
    for (int i = 0; i < TO - 1; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, "exp_idle");
    end
    step(1, 8'h11, 1, 8'h11, 0, 1, 0, 0, "exp_win");
    step(1, 8'h22, 1, 8'h22, 0, 1, 0, 0, "exp_b1");
    step(1, 8'h33, 0, 8'h00, 0, 0, 1, 0, "exp_chk");

    // Reset mid-payload clears outputs without a clock edge.
    step(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, "r6_sync");
    step(1, 8'h01, 0, 8'h00, 0, 1, 0, 0, "r6_len");
    step(1, 8'h11, 1, 8'h11, 0, 1, 0, 0, "r6_b0");
    #2;
    reset = 1'b0;
    #1;
    check(0, 8'h00, 0, 0, 0, 0, "r6_async");
    @(negedge clk);
    reset = 1'b1;
    step(1, 8'h22, 0, 8'h00, 0, 0, 0, 0, "r6_drop22");
    step(1, 8'h33, 0, 8'h00, 0, 0, 0, 0, "r6_drop33");
    step(1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, "r6g_sync");
    step(1, 8'h01, 0, 8'h00, 0, 1, 0, 0, "r6g_len");
    step(1, 8'h0F, 1, 8'h0F, 0, 1, 0, 0, "r6g_b0");
    step(1, 8'hF0, 1, 8'hF0, 0, 1, 0, 0, "r6g_b1");
    step(1, 8'hFF, 0, 8'h00, 0, 0, 1, 0, "r6g_chk");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
